// File: rtl/fir_tdm_mac_scheduler.sv
// Time-multiplexed direct-form FIR: one signed MAC sequenced over ORDER taps per sample.
// Optional FIR_SAT_EN: saturate the output instead of wrapping and expose sat_flag.
module fir_tdm_mac_scheduler #(
    parameter int ORDER  = 53,
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 64,
    parameter int SCALE  = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    input  logic                       coef_wr_en,
    input  logic [$clog2(ORDER)-1:0]   coef_wr_addr,
    input  logic [COEF_W-1:0]          coef_wr_data,
    output logic                       coef_err,
    output logic                       busy
`ifdef FIR_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam int AW = $clog2(ORDER);
    localparam int PW = DATA_W + COEF_W;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

    state_t                    state;
    logic signed [DATA_W-1:0]  samp_mem [ORDER];
    logic signed [COEF_W-1:0]  coef_mem [ORDER];
    logic signed [ACC_W-1:0]   acc;
    logic [AW-1:0]             k;
    logic [AW-1:0]             head;
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             idx;
    logic signed [PW-1:0]      prod;
    logic                      coef_ok;

    // Newest sample sits at head; tap k reads k entries back, wrapping below 0.
    always_comb begin
        int tap_i;
        tap_i = int'(head) - int'(k);
        if (k > head)
            tap_i = tap_i + ORDER;
        idx = AW'(tap_i);
    end

    assign prod    = PW'(coef_mem[k]) * PW'(samp_mem[idx]);
    assign coef_ok = (state == IDLE) && (int'(coef_wr_addr) < ORDER);

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       res;
    logic                    res_sat;

    // Clip when the bits above the output sign bit disagree with the accumulator sign.
    always_comb begin
        shifted = acc >>> SCALE;
        res     = shifted[DATA_W-1:0];
        res_sat = 1'b0;
        if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:DATA_W-1])) begin
            res     = {1'b0, {(DATA_W-1){1'b1}}};
            res_sat = 1'b1;
        end else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:DATA_W-1])) begin
            res     = {1'b1, {(DATA_W-1){1'b0}}};
            res_sat = 1'b1;
        end
    end
`else
    logic [DATA_W-1:0] res;
    assign res = DATA_W'(acc >>> SCALE);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            for (int unsigned i = 0; i < ORDER; i++) begin
                samp_mem[i] <= '0;
                coef_mem[i] <= '0;
            end
            acc       <= '0;
            k         <= '0;
            head      <= '0;
            wr_ptr    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
            busy      <= 1'b0;
`ifdef FIR_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            coef_err <= coef_wr_en && !coef_ok;
            if (coef_wr_en && coef_ok)
                coef_mem[coef_wr_addr] <= coef_wr_data;

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        samp_mem[wr_ptr] <= in_data;
                        head     <= wr_ptr;
                        wr_ptr   <= (wr_ptr == AW'(ORDER - 1)) ? '0 : wr_ptr + AW'(1);
                        acc      <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOAD: state <= MAC;
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == AW'(ORDER - 1))
                        state <= OUT;
                    else
                        k <= k + AW'(1);
                end
                OUT: begin
                    // First OUT cycle registers the scaled result; it then holds until taken.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= res;
`ifdef FIR_SAT_EN
                        sat_flag  <= res_sat;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac_scheduler.sv
// Bench for fir_tdm_mac_scheduler (ORDER=4); a queue-based convolution model supplies every expected output.
module tb_fir_tdm_mac_scheduler;

    localparam int ORDER = 4;
    localparam int SCALE = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic        coef_wr_en = 1'b0;
    logic [1:0]  coef_wr_addr = '0;
    logic [31:0] coef_wr_data = '0;
    logic        coef_err;
    logic        busy;

    logic        in_ready5, out_valid5, coef_err5, busy5;
    logic [31:0] out_data5;
    logic        c5_en = 1'b0;
    logic [2:0]  c5_addr = '0;
`ifdef FIR_SAT_EN
    logic        sat_flag, sat_flag5;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    int coef_m [ORDER];
    int hist_q [$];

    always #5 clk = ~clk;

    fir_tdm_mac_scheduler #(.ORDER(ORDER), .DATA_W(32), .COEF_W(32), .ACC_W(64), .SCALE(SCALE)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .coef_err(coef_err), .busy(busy)
`ifdef FIR_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    // Non-power-of-two depth so out-of-range tap addresses are representable.
    fir_tdm_mac_scheduler #(.ORDER(5), .DATA_W(32), .COEF_W(32), .ACC_W(64), .SCALE(SCALE)) dut5 (
        .clk(clk), .reset_n(reset_n), .in_valid(1'b0), .in_data(32'd0), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_ready(1'b1),
        .coef_wr_en(c5_en), .coef_wr_addr(c5_addr), .coef_wr_data(32'd1),
        .coef_err(coef_err5), .busy(busy5)
`ifdef FIR_SAT_EN
        , .sat_flag(sat_flag5)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        foreach (coef_m[i]) coef_m[i] = 0;
        hist_q.delete();
    endfunction

    function automatic void model_push(input int d);
        hist_q.push_front(d);
        if (hist_q.size() > ORDER) void'(hist_q.pop_back());
    endfunction

    function automatic void model_out(output logic [31:0] r, output bit s);
        longint acc;
        acc = 0;
        for (int j = 0; j < hist_q.size(); j++)
            acc += longint'(coef_m[j]) * longint'(hist_q[j]);
        acc = acc >>> SCALE;
        r = acc[31:0];
        s = 1'b0;
`ifdef FIR_SAT_EN
        if (acc > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF;
            s = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            r = 32'h8000_0000;
            s = 1'b1;
        end
`endif
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_wr_en = 1'b1;
        coef_wr_addr = 2'(addr);
        coef_wr_data = data;
        tick();
        coef_wr_en = 1'b0;
        coef_m[addr] = data;
    endtask

    // Drives one sample through with out_ready high; reports result, latency and handshake leaks.
    task automatic run_sample(input logic [31:0] d, output logic [31:0] got, output bit s,
                              output int lat, output bit leak);
        int g;
        g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        lat = 0;
        leak = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready || !busy) leak = 1'b1;
            tick();
            lat++;
        end
        got = out_data;
`ifdef FIR_SAT_EN
        s = sat_flag;
`else
        s = 1'b0;
`endif
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL reset_coef_err got=%b exp=0", coef_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        model_reset();
    endtask

    task automatic test_impulse();
        logic [31:0] got, exp;
        bit s, es, leak;
        int lat;
        logic [31:0] seq [5];
        seq = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < ORDER; i++) write_coef(i, i + 1);
        foreach (seq[i]) begin
            run_sample(seq[i], got, s, lat, leak);
            model_push(int'(seq[i]));
            model_out(exp, es);
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL impulse_out[%0d] got=%0d exp=%0d", i, got, exp); end
            n_cmp++; if (lat !== ORDER + 2) begin n_fail++; $display("FAIL impulse_latency[%0d] got=%0d exp=%0d", i, lat, ORDER + 2); end
            n_cmp++; if (leak !== 1'b0) begin n_fail++; $display("FAIL impulse_ready_busy[%0d] got=%b exp=0", i, leak); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, exp;
        bit es;
        int g;
        do_reset();
        for (int i = 0; i < ORDER; i++) write_coef(i, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd5;
        tick();
        in_data = 32'd7;
        model_push(5);
        model_out(exp, es);
        g = 0;
        while (!out_valid && g < 40) begin tick(); g++; end
        n_cmp++; if (g !== ORDER + 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", g, ORDER + 2); end
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin
                n_fail++; $display("FAIL bp_hold[%0d] got=%b/%0d exp=1/%0d", c, out_valid, out_data, exp);
            end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        tick();
        in_valid = 1'b0;
        model_push(7);
        model_out(exp, es);
        g = 0;
        while (!out_valid && g < 40) begin tick(); g++; end
        got = out_data;
        n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL bp_second got=%0d exp=%0d", got, exp); end
        tick();
    endtask

    task automatic test_coef_reject();
        logic [31:0] got, exp;
        bit s, es, leak;
        int lat, g;
        do_reset();
        for (int i = 0; i < ORDER; i++) write_coef(i, i + 1);
        n_cmp++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL good_write_err got=%b exp=0", coef_err); end
        in_valid = 1'b1;
        in_data = 32'd1;
        tick();
        in_valid = 1'b0;
        tick();
        coef_wr_en = 1'b1;
        coef_wr_addr = 2'd1;
        coef_wr_data = 32'd9;
        tick();
        coef_wr_en = 1'b0;
        n_cmp++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL mac_write_err got=%b exp=1", coef_err); end
        tick();
        n_cmp++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL mac_write_err_pulse got=%b exp=0", coef_err); end
        g = 0;
        while (!out_valid && g < 40) begin tick(); g++; end
        model_push(1);
        model_out(exp, es);
        n_cmp++; if (out_data !== exp) begin n_fail++; $display("FAIL reject_out[0] got=%0d exp=%0d", out_data, exp); end
        tick();
        for (int i = 1; i < ORDER; i++) begin
            run_sample(32'd0, got, s, lat, leak);
            model_push(0);
            model_out(exp, es);
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL reject_out[%0d] got=%0d exp=%0d", i, got, exp); end
        end
        c5_en = 1'b1;
        c5_addr = 3'd4;
        tick();
        c5_en = 1'b0;
        n_cmp++; if (coef_err5 !== 1'b0) begin n_fail++; $display("FAIL addr_last_err got=%b exp=0", coef_err5); end
        for (int a = 5; a < 8; a++) begin
            c5_en = 1'b1;
            c5_addr = 3'(a);
            tick();
            c5_en = 1'b0;
            n_cmp++; if (coef_err5 !== 1'b1) begin n_fail++; $display("FAIL addr_range_err[%0d] got=%b exp=1", a, coef_err5); end
            tick();
            n_cmp++; if (coef_err5 !== 1'b0) begin n_fail++; $display("FAIL addr_range_pulse[%0d] got=%b exp=0", a, coef_err5); end
        end
    endtask

    task automatic test_signed_wrap();
        logic [31:0] got, exp;
        bit s, es, leak;
        int lat;
        do_reset();
        for (int i = 0; i < ORDER; i++) write_coef(i, 65536);
        for (int i = 0; i < ORDER; i++) begin
            run_sample(32'd65536, got, s, lat, leak);
            model_push(65536);
            model_out(exp, es);
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL wrap_out[%0d] got=%h exp=%h", i, got, exp); end
`ifdef FIR_SAT_EN
            n_cmp++; if (s !== es) begin n_fail++; $display("FAIL wrap_sat_flag[%0d] got=%b exp=%b", i, s, es); end
`endif
        end
        do_reset();
        write_coef(0, -3);
        run_sample(32'd7, got, s, lat, leak);
        model_push(7);
        model_out(exp, es);
        n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL negative_out got=%h exp=%h", got, exp); end
`ifdef FIR_SAT_EN
        n_cmp++; if (s !== es) begin n_fail++; $display("FAIL negative_sat_flag got=%b exp=%b", s, es); end
`endif
    endtask

    task automatic test_same_edge();
        logic [31:0] exp;
        bit es;
        int g;
        do_reset();
        for (int i = 0; i < ORDER; i++) write_coef(i, i + 2);
        coef_wr_en = 1'b1;
        coef_wr_addr = 2'd0;
        coef_wr_data = 32'hFFFF_FFF9;
        in_valid = 1'b1;
        in_data = 32'd11;
        tick();
        coef_wr_en = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL same_edge_err got=%b exp=0", coef_err); end
        coef_m[0] = -7;
        model_push(11);
        model_out(exp, es);
        g = 0;
        while (!out_valid && g < 40) begin tick(); g++; end
        n_cmp++; if (out_data !== exp) begin n_fail++; $display("FAIL same_edge_out got=%h exp=%h", out_data, exp); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] got, exp, d;
        bit s, es, leak;
        int lat;
        do_reset();
        for (int i = 0; i < ORDER; i++)
            write_coef(i, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 200)) - 100 : int'($urandom));
        for (int n = 0; n < 12; n++) begin
            d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            run_sample(d, got, s, lat, leak);
            model_push(int'(d));
            model_out(exp, es);
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL random_out[%0d] got=%h exp=%h", n, got, exp); end
            n_cmp++; if (lat !== ORDER + 2) begin n_fail++; $display("FAIL random_latency[%0d] got=%0d exp=%0d", n, lat, ORDER + 2); end
`ifdef FIR_SAT_EN
            n_cmp++; if (s !== es) begin n_fail++; $display("FAIL random_sat_flag[%0d] got=%b exp=%b", n, s, es); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        bit s, es, leak, seen;
        int lat;
        do_reset();
        for (int i = 0; i < ORDER; i++) write_coef(i, i + 1);
        in_valid = 1'b1;
        in_data = 32'd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        model_reset();
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_stale_out got=%b exp=0", seen); end
        for (int i = 0; i < ORDER; i++) begin
            run_sample((i == 0) ? 32'd1 : 32'd0, got, s, lat, leak);
            model_push((i == 0) ? 1 : 0);
            model_out(exp, es);
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL midreset_out[%0d] got=%0d exp=%0d", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_coef_reject();
        test_signed_wrap();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
